// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU and load result paths via round-robin.
// Latency: accept at edge E0, wb_we/wb_rd/wb_data registered at E1 (2 edges accept-to-regfile-write).
// Backpressure: per-port ready is low only while that port's buffer is full and loses arbitration.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       pending,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which port won the most recent grant; the other one wins the next tie.
  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } sel_e;

  logic      alu_full, mem_full;
  wb_entry_t alu_buf, mem_buf;
  sel_e      last_grant;
  logic      grant_alu, grant_mem;
  logic      alu_acc, mem_acc;

  // Round-robin grant from registered state; a port being drained may refill in the same cycle.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full && mem_full) begin
      grant_alu = (last_grant == SEL_MEM);
      grant_mem = (last_grant == SEL_ALU);
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
    alu_ready = !alu_full || grant_alu;
    mem_ready = !mem_full || grant_mem;
    alu_acc   = alu_valid && alu_ready;
    mem_acc   = mem_valid && mem_ready;
  end

  // Destinations with a write still in flight; x0 never shows as pending.
  always_comb begin
    pending = '0;
    if (alu_full && alu_buf.rd != 5'd0) pending[alu_buf.rd] = 1'b1;
    if (mem_full && mem_buf.rd != 5'd0) pending[mem_buf.rd] = 1'b1;
    if (wb_we) pending[wb_rd] = 1'b1;
  end

  // One-entry holding buffers: fill on handshake, clear on grant unless refilled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_full <= 1'b0;
      mem_full <= 1'b0;
      alu_buf  <= '0;
      mem_buf  <= '0;
    end else begin
      alu_full <= alu_acc || (alu_full && !grant_alu);
      mem_full <= mem_acc || (mem_full && !grant_mem);
      if (alu_acc) alu_buf <= '{rd: alu_rd, data: alu_data};
      if (mem_acc) mem_buf <= '{rd: mem_rd, data: mem_data};
    end
  end

  // Write-port stage: register the granted entry; without a grant only the enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      last_grant <= SEL_MEM;
    end else if (grant_alu) begin
      wb_we      <= (alu_buf.rd != 5'd0);
      wb_rd      <= alu_buf.rd;
      wb_data    <= alu_buf.data;
      last_grant <= SEL_ALU;
    end else if (grant_mem) begin
      wb_we      <= (mem_buf.rd != 5'd0);
      wb_rd      <= mem_buf.rd;
      wb_data    <= mem_buf.data;
      last_grant <= SEL_MEM;
    end else begin
      wb_we      <= 1'b0;
    end
  end

  // Saturating count of cycles where both buffers hold an entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (alu_full && mem_full && conflict_cnt != {CNT_W{1'b1}}) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed stimulus for regfile_wb_arbiter against a queue-based reference model.
// Outputs compared every cycle at the falling edge; explicit constant checks for key scenarios.
// Inputs are driven regardless of ready; the model decides which offers are accepted.
module tb_regfile_wb_arbiter;

  localparam int DATA_W  = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       pending;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .pending      (pending),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each port holds at most one outstanding write in a queue.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        alu_q[$];
  ent_t        mem_q[$];
  bit          alu_wins_tie = 1'b1;
  bit          m_we   = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [63:0] m_data = '0;
  int          m_cnt  = 0;

  function automatic logic [31:0] model_pending();
    logic [31:0] m;
    m = '0;
    foreach (alu_q[i]) if (alu_q[i].rd != 0) m[alu_q[i].rd] = 1'b1;
    foreach (mem_q[i]) if (mem_q[i].rd != 0) m[mem_q[i].rd] = 1'b1;
    if (m_we) m[m_rd] = 1'b1;
    return m;
  endfunction

  // One clock: drive inputs at the falling edge, compare, advance the model, wait for the rising edge.
  task automatic cycle(input logic rst,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md);
    int   served;
    bit   exp_ardy, exp_mrdy;
    ent_t e;
    @(negedge clk);
    reset     = rst;
    alu_valid = av;  alu_rd = ard; alu_data = ad;
    mem_valid = mv;  mem_rd = mrd; mem_data = md;
    #1;
    if (alu_q.size() > 0 && mem_q.size() > 0) served = alu_wins_tie ? 1 : 2;
    else if (alu_q.size() > 0)                served = 1;
    else if (mem_q.size() > 0)                served = 2;
    else                                      served = 0;
    exp_ardy = (alu_q.size() == 0) || (served == 1);
    exp_mrdy = (mem_q.size() == 0) || (served == 2);
    check("alu_ready",    64'(alu_ready),    64'(exp_ardy));
    check("mem_ready",    64'(mem_ready),    64'(exp_mrdy));
    check("wb_we",        64'(wb_we),        64'(m_we));
    check("wb_rd",        64'(wb_rd),        64'(m_rd));
    check("wb_data",      64'(wb_data),      m_data);
    check("pending",      64'(pending),      64'(model_pending()));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (rst) begin
      alu_q.delete();
      mem_q.delete();
      alu_wins_tie = 1'b1;
      m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
    end else begin
      if (alu_q.size() > 0 && mem_q.size() > 0 && m_cnt < CNT_MAX) m_cnt++;
      if (served == 1) begin
        e = alu_q.pop_front();
        m_we = (e.rd != 0); m_rd = e.rd; m_data = e.data;
        alu_wins_tie = 1'b0;
      end else if (served == 2) begin
        e = mem_q.pop_front();
        m_we = (e.rd != 0); m_rd = e.rd; m_data = e.data;
        alu_wins_tie = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (av && exp_ardy) alu_q.push_back('{rd: ard, data: ad});
      if (mv && exp_mrdy) mem_q.push_back('{rd: mrd, data: md});
    end
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 5'd7, 64'h77, 1'b1, 5'd9, 64'h99);
  endtask

  task automatic random_cycle(input int rst_pct);
    logic       rst;
    logic [4:0] ard, mrd;
    rst = ($urandom_range(0, 99) < rst_pct);
    ard = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    mrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    cycle(rst, 1'($urandom_range(0, 1)), ard, {$urandom, $urandom},
               1'($urandom_range(0, 1)), mrd, {$urandom, $urandom});
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // Reset state, with offers present to show reset wins over accept.
    do_reset();
    do_reset();
    #1;
    check("rst_wb_we",   64'(wb_we),        64'd0);
    check("rst_wb_rd",   64'(wb_rd),        64'd0);
    check("rst_wb_data", wb_data,           64'd0);
    check("rst_pending", 64'(pending),      64'd0);
    check("rst_cnt",     64'(conflict_cnt), 64'd0);
    check("rst_aready",  64'(alu_ready),    64'd1);
    check("rst_mready",  64'(mem_ready),    64'd1);

    // Single ALU write to x5.
    cycle(1'b0, 1'b1, 5'd5, 64'hAAAA, 1'b0, 5'd0, 64'd0);
    #1 check("single_pending", 64'(pending), 64'h20);
    idle();
    #1;
    check("single_we",   64'(wb_we),   64'd1);
    check("single_rd",   64'(wb_rd),   64'd5);
    check("single_data", wb_data,      64'hAAAA);
    idle();
    #1 check("single_clear", 64'(pending), 64'd0);

    // Simultaneous offers: ALU wins the first tie after reset.
    do_reset();
    cycle(1'b0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
    idle();
    #1;
    check("sim_first_rd",   64'(wb_rd),        64'd3);
    check("sim_first_data", wb_data,           64'h11);
    check("sim_cnt",        64'(conflict_cnt), 64'd1);
    idle();
    #1;
    check("sim_second_rd",   64'(wb_rd),   64'd4);
    check("sim_second_data", wb_data,      64'h22);
    idle();

    // Sustained contention with incrementing data.
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 5'(10 + i), 64'(2 * i), 1'b1, 5'(20 + i), 64'(2 * i + 1));
    for (int i = 0; i < 4; i++) idle();

    // Write to x0 via the load path.
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF);
    #1 check("x0_pending", 64'(pending), 64'd0);
    idle();
    #1 check("x0_we", 64'(wb_we), 64'd0);

    // Reset mid-flight with both buffers full.
    cycle(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    cycle(1'b0, 1'b1, 5'd6, 64'h6, 1'b1, 5'd8, 64'h8);
    do_reset();
    #1;
    check("mid_we",     64'(wb_we),        64'd0);
    check("mid_pend",   64'(pending),      64'd0);
    check("mid_cnt",    64'(conflict_cnt), 64'd0);
    check("mid_aready", 64'(alu_ready),    64'd1);
    check("mid_mready", 64'(mem_ready),    64'd1);
    cycle(1'b0, 1'b1, 5'd12, 64'hC, 1'b1, 5'd13, 64'hD);
    idle();
    #1 check("mid_tie_alu", 64'(wb_rd), 64'd12);
    idle();
    idle();

    // Counter saturation under long contention.
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 5'(i), 64'(i), 1'b1, 5'(31 - i), 64'(100 + i));
    #1 check("cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));
    for (int i = 0; i < 3; i++) idle();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) random_cycle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
